// File: rtl/alu_pkg.sv
// Shared ALU definitions: divide-op encodings from the ALU decode and the
// divider FSM state type. Also consumed by alu_control.
package alu_pkg;

  // Divide op encodings carried on the 2-bit control field.
  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10
  } div_state_e;

  // Signed variants (div, rem) have control[0] clear.
  function automatic logic op_is_signed(logic [1:0] op);
    return ~op[0];
  endfunction

  // Remainder variants (rem, remu) have control[1] set.
  function automatic logic op_is_rem(logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (purely combinational).
// Ports:
//   rem_in  - partial remainder so far (always < divisor)
//   quo_in  - shift register: remaining dividend bits on top, quotient bits below
//   divisor - unsigned divisor magnitude (non-zero)
//   rem_out - updated partial remainder
//   quo_out - quo_in shifted left by one with the new quotient bit in the LSB
module div_step #(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          q_bit;

  always_comb begin
    // Bring down the next dividend bit (MSB first).
    shifted = {rem_in, quo_in[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    // rem_in < divisor keeps a non-negative diff below 2^XLEN, so the top bit
    // is a clean borrow flag.
    q_bit   = ~diff[XLEN];
    rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_out = {quo_in[XLEN-2:0], q_bit};
  end

endmodule

// File: rtl/alu_divider.sv
// Iterative restoring divider for the ALU: div, divu, rem, remu.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - request handshake (ready only when idle)
//   control, a, b        - op select, dividend, divisor (captured on accept)
//   flush                - synchronous abort of any in-flight operation
//   out_valid / out_ready- result handshake
//   result               - quotient or remainder, zero when out_valid is low
//   busy                 - high whenever not idle
module alu_divider
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      control,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned     CntW     = $clog2(XLEN) + 1;
  localparam logic [CntW-1:0] LastIter = CntW'(XLEN - 1);
  localparam logic [XLEN-1:0] MinNeg   = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q, state_d;
  logic            is_rem_q, is_rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] divisor_q, divisor_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            sgn, a_neg, b_neg;
  logic            div_by_zero, overflow;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] step_rem, step_quo;
  logic [XLEN-1:0] quo_fin, rem_fin;

  div_step #(
    .XLEN(XLEN)
  ) u_div_step (
    .rem_in (rem_q),
    .quo_in (quo_q),
    .divisor(divisor_q),
    .rem_out(step_rem),
    .quo_out(step_quo)
  );

  // Operand preparation on the live inputs, used only in the accept cycle.
  always_comb begin
    sgn         = op_is_signed(control);
    a_neg       = sgn & a[XLEN-1];
    b_neg       = sgn & b[XLEN-1];
    a_mag       = a_neg ? -a : a;
    b_mag       = b_neg ? -b : b;
    div_by_zero = (b == '0);
    overflow    = sgn & (a == MinNeg) & (b == '1);
    // Sign fix-up applied to the final iteration's outputs.
    quo_fin     = neg_quo_q ? -step_quo : step_quo;
    rem_fin     = neg_rem_q ? -step_rem : step_rem;
  end

  always_comb begin
    state_d   = state_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    res_d     = res_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          is_rem_d = op_is_rem(control);
          if (div_by_zero) begin
            res_d   = op_is_rem(control) ? a : '1;
            state_d = StDone;
          end else if (overflow) begin
            res_d   = op_is_rem(control) ? '0 : a;
            state_d = StDone;
          end else begin
            divisor_d = b_mag;
            quo_d     = a_mag;
            rem_d     = '0;
            cnt_d     = '0;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            state_d   = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == LastIter) begin
          res_d   = is_rem_q ? rem_fin : quo_fin;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        // No accept in the handshake cycle: in_ready is only high in StIdle.
        if (out_ready) begin
          res_d   = '0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Flush wins over a same-cycle accept or handshake.
    if (flush) begin
      res_d   = '0;
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q != StIdle);
    out_valid = (state_q == StDone);
    result    = out_valid ? res_q : '0;
  end

endmodule

// File: tb/tb_alu_divider.sv
// Scoreboard bench for alu_divider (XLEN=64): directed vectors, hold/backpressure,
// reset and flush aborts, then randomized ops against a behavioural model.
module tb_alu_divider;
  import alu_pkg::*;

  localparam int unsigned XLEN = 64;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      control = 2'b00;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result;
  logic            busy;

  always #5 clk = ~clk;

  alu_divider #(
    .XLEN(XLEN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .control  (control),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy)
  );

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] res;
    int          lat;
  } vec_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   spurious = 0;
  bit   seen_valid = 1'b0;
  bit   prev_valid = 1'b0;
  int   ready_mode = 0;  // 0: always ready, 1: never ready, 2: random

  always @(posedge clk) cyc <= cyc + 1;

  // Sole driver of out_ready; runs after the main process's posedge+1 updates.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
  endtask

  // Reference model straight from the arithmetic rules.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [63:0] x,
                                        input logic [63:0] y);
    longint sx, sy;
    sx = x;
    sy = y;
    if (y == 64'd0) return (op == REM || op == REMU) ? x : '1;
    case (op)
      DIV:     return (x == MINV && y == '1) ? x : 64'(sx / sy);
      REM:     return (x == MINV && y == '1) ? 64'd0 : 64'(sx % sy);
      DIVU:    return x / y;
      default: return x % y;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [63:0] x,
                                   input logic [63:0] y);
    if (y == 64'd0) return 1;
    if ((op == DIV || op == REM) && x == MINV && y == '1) return 1;
    return XLEN + 1;
  endfunction

  // Monitor: latency on the first valid cycle, result on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen_valid = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !seen_valid) begin
        seen_valid = 1'b1;
        if (sb.size() == 0) begin
          spurious++;
          n_checks++;
          $display("FAIL unexpected_out_valid: got out_valid=1 result=0x%h, required no output",
                   result);
        end else begin
          check("latency", 64'(cyc), 64'(sb[0].cyc));
        end
      end
      if (out_valid && out_ready) begin
        if (sb.size() > 0) begin
          check("result", result, sb[0].res);
          void'(sb.pop_front());
        end
        seen_valid = 1'b0;
      end
      if (!out_valid && prev_valid) check("result_zero_when_invalid", result, 64'd0);
      if (!out_valid) seen_valid = 1'b0;
      prev_valid = out_valid;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [63:0] x, input logic [63:0] y,
                       input logic [63:0] exp_res, input int lat, input bit track,
                       output int t);
    int waited;
    waited = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    control  = op;
    a        = x;
    b        = y;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 300) begin
        n_checks++;
        $display("FAIL accept_timeout: in_ready=0 for %0d cycles, required 1", waited);
        break;
      end
    end
    t = cyc;
    if (track) sb.push_back('{res: exp_res, cyc: t + lat});
    @(posedge clk);
    #1;
    // Scramble inputs after accept; the captured op must be unaffected.
    in_valid = 1'b0;
    control  = 2'($urandom);
    a        = {$urandom, $urandom};
    b        = {$urandom, $urandom};
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t dir[10];
    int   t, n, sp0;

    dir[0] = '{DIV,  64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA, 65};
    dir[1] = '{REM,  64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 65};
    dir[2] = '{REM,  64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    dir[3] = '{REMU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'd15, 65};
    dir[4] = '{DIVU, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    dir[5] = '{REMU, 64'd7, 64'd0, 64'd7, 1};
    dir[6] = '{DIV,  MINV, 64'hFFFF_FFFF_FFFF_FFFF, MINV, 1};
    dir[7] = '{REM,  MINV, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
    dir[8] = '{DIVU, MINV, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65};
    dir[9] = '{DIVU, 64'd100, 64'd7, 64'd14, 65};

    // Reset state.
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // Directed vectors.
    foreach (dir[i]) issue(dir[i].op, dir[i].x, dir[i].y, dir[i].res, dir[i].lat, 1'b1, t);
    drain();

    // Backpressure: result held while out_ready low, requests ignored.
    ready_mode = 1;
    issue(DIVU, 64'd1000, 64'd3, 64'd333, 65, 1'b1, t);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hold_reached_done", out_valid, 1);
    repeat (10) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom_range(0, 1));
      control  = 2'($urandom);
      a        = {$urandom, $urandom};
      b        = {$urandom, $urandom};
      @(negedge clk);
      check("hold_result", result, 64'd333);
      check("hold_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    ready_mode = 0;
    @(negedge clk);
    @(negedge clk);
    check("ready_after_handshake", in_ready, 1);
    check("valid_after_handshake", out_valid, 0);
    drain();

    // Reset mid-calculation discards the op.
    issue(DIV, 64'd1000000, 64'd7, 64'd0, 0, 1'b0, t);
    while (cyc < t + 30) @(posedge clk);
    #1;
    sp0   = spurious;
    rst_n = 1'b0;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_in_ready", in_ready, 1);
    repeat (80) @(negedge clk);
    check("midreset_no_output", 64'(spurious - sp0), 0);
    issue(DIVU, 64'd100, 64'd7, 64'd14, 65, 1'b1, t);
    drain();

    // Flush mid-calculation discards the op.
    issue(REMU, 64'd123456789, 64'd1000, 64'd0, 0, 1'b0, t);
    while (cyc < t + 30) @(posedge clk);
    #1;
    sp0   = spurious;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", busy, 0);
    check("flush_in_ready", in_ready, 1);
    repeat (80) @(negedge clk);
    check("flush_no_output", 64'(spurious - sp0), 0);
    issue(DIVU, 64'd100, 64'd7, 64'd14, 65, 1'b1, t);
    drain();

    // Flush beats a same-cycle accept.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    control  = DIVU;
    a        = 64'd5;
    b        = 64'd0;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    check("flush_blocks_accept", busy, 0);

    // Randomized ops with random backpressure.
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [63:0] x, y;
      int          mode;
      op   = 2'($urandom);
      x    = {$urandom, $urandom};
      y    = {$urandom, $urandom};
      mode = $urandom_range(0, 7);
      case (mode)
        0: y = 64'd0;
        1: begin x = MINV; y = '1; end
        2: begin x = 64'($urandom_range(0, 1000)); y = 64'($urandom_range(1, 50)); end
        3: y = -64'($urandom_range(1, 50));
        4: x = -64'($urandom_range(0, 100000));
        default: ;
      endcase
      issue(op, x, y, model(op, x, y), model_lat(op, x, y), 1'b1, t);
    end
    drain();
    ready_mode = 0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
